// File: rtl/fsm_link_host.sv
// Host-side master for the nibble-serial operate/readback link: streams an operand pair,
// plays a short op_val program, then reassembles the nibble-serial result into one word.
module fsm_link_host #(
  parameter int         N        = 64,
  parameter int         NW       = 4,
  parameter int         PROG_MAX = 8,
  parameter int         TIMEOUT  = 255,
  parameter logic [1:0] IDLE_OP  = 2'b01
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [N-1:0]                   req_a,
  input  logic [N-1:0]                   req_b,
  input  logic [2*PROG_MAX-1:0]          req_prog,
  input  logic [$clog2(PROG_MAX+1)-1:0]  req_prog_len,
  output logic                           resp_valid,
  output logic [N-1:0]                   resp_result,
  output logic                           resp_error,
  output logic                           busy,
  output logic                           link_start,
  output logic                           link_input_enable,
  output logic [NW-1:0]                  link_a,
  output logic [NW-1:0]                  link_b,
  output logic [1:0]                     link_op_val,
  input  logic [NW-1:0]                  link_out,
  input  logic                           link_output_valid
);

  localparam int K  = N / NW;
  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam int LW = $clog2(PROG_MAX + 1);
  localparam int PW = (PROG_MAX > 1) ? $clog2(PROG_MAX) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    SEND  = 3'd2,
    PROG  = 3'd3,
    WAIT  = 3'd4,
    RECV  = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t                state_reg;
  logic [N-1:0]          a_reg;
  logic [N-1:0]          b_reg;
  logic [2*PROG_MAX-1:0] prog_reg;
  logic [LW-1:0]         len_reg;
  logic [N-1:0]          result_reg;
  logic [CW-1:0]         cnt_reg;
  logic [PW-1:0]         pidx_reg;
  logic [TW-1:0]         timer_reg;

  logic [NW-1:0]         a_nib    [K];
  logic [NW-1:0]         b_nib    [K];
  logic [1:0]            prog_code [PROG_MAX];
  logic [N-1:0]          result_ins;
  logic [CW-1:0]         cnt_next;
  logic [PW-1:0]         pidx_next;
  logic [LW-1:0]         len_clamped;
  logic                  prog_last;

  // Nibble views of the latched operands, and the result word with link_out merged at cnt
  genvar gi;
  generate
    for (gi = 0; gi < K; gi++) begin : g_nib
      assign a_nib[gi] = a_reg[gi*NW +: NW];
      assign b_nib[gi] = b_reg[gi*NW +: NW];
      assign result_ins[gi*NW +: NW] = (cnt_reg == CW'(gi)) ? link_out : result_reg[gi*NW +: NW];
    end
    for (gi = 0; gi < PROG_MAX; gi++) begin : g_prog
      assign prog_code[gi] = prog_reg[2*gi +: 2];
    end
  endgenerate

  assign cnt_next    = cnt_reg + CW'(1);
  assign pidx_next   = pidx_reg + PW'(1);
  assign len_clamped = (req_prog_len > LW'(PROG_MAX)) ? LW'(PROG_MAX) : req_prog_len;
  assign prog_last   = (LW'(pidx_reg) == (len_reg - LW'(1)));

  assign req_ready = (state_reg == IDLE);
  assign busy      = ~req_ready;

  // Link outputs are updated on the transition into each state so they line up with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= IDLE;
      a_reg             <= '0;
      b_reg             <= '0;
      prog_reg          <= '0;
      len_reg           <= '0;
      result_reg        <= '0;
      cnt_reg           <= '0;
      pidx_reg          <= '0;
      timer_reg         <= '0;
      link_start        <= 1'b0;
      link_input_enable <= 1'b0;
      link_a            <= '0;
      link_b            <= '0;
      link_op_val       <= IDLE_OP;
      resp_valid        <= 1'b0;
      resp_result       <= '0;
      resp_error        <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            a_reg      <= req_a;
            b_reg      <= req_b;
            prog_reg   <= req_prog;
            len_reg    <= len_clamped;
            result_reg <= '0;
            link_start <= 1'b1;
            state_reg  <= START;
          end
        end

        START: begin
          link_start        <= 1'b0;
          link_input_enable <= 1'b1;
          link_a            <= a_nib[0];
          link_b            <= b_nib[0];
          cnt_reg           <= '0;
          state_reg         <= SEND;
        end

        SEND: begin
          if (cnt_reg == CW'(K-1)) begin
            link_input_enable <= 1'b0;
            link_a            <= '0;
            link_b            <= '0;
            pidx_reg          <= '0;
            timer_reg         <= '0;
            if (len_reg != '0) begin
              link_op_val <= prog_code[0];
              state_reg   <= PROG;
            end else begin
              state_reg   <= WAIT;
            end
          end else begin
            link_a  <= a_nib[cnt_next];
            link_b  <= b_nib[cnt_next];
            cnt_reg <= cnt_next;
          end
        end

        PROG: begin
          if (link_output_valid) begin
            // Early readback: the rest of the program is abandoned
            result_reg  <= {{(N-NW){1'b0}}, link_out};
            cnt_reg     <= CW'(1);
            link_op_val <= IDLE_OP;
            state_reg   <= RECV;
          end else if (prog_last) begin
            link_op_val <= IDLE_OP;
            state_reg   <= WAIT;
          end else begin
            link_op_val <= prog_code[pidx_next];
            pidx_reg    <= pidx_next;
          end
        end

        WAIT: begin
          if (link_output_valid) begin
            result_reg <= {{(N-NW){1'b0}}, link_out};
            cnt_reg    <= CW'(1);
            state_reg  <= RECV;
          end else if (timer_reg == TW'(TIMEOUT-1)) begin
            resp_valid  <= 1'b1;
            resp_result <= result_reg;
            resp_error  <= 1'b1;
            state_reg   <= DONE;
          end else begin
            timer_reg <= timer_reg + TW'(1);
          end
        end

        RECV: begin
          if (link_output_valid) begin
            result_reg <= result_ins;
            if (cnt_reg == CW'(K-1)) begin
              resp_valid  <= 1'b1;
              resp_result <= result_ins;
              resp_error  <= 1'b0;
              state_reg   <= DONE;
            end else begin
              cnt_reg <= cnt_next;
            end
          end else begin
            // Short readback: keep the nibbles collected so far, upper ones stay zero
            resp_valid  <= 1'b1;
            resp_result <= result_reg;
            resp_error  <= 1'b1;
            state_reg   <= DONE;
          end
        end

        DONE: begin
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
